// File: rtl/byte_stream_fifo.sv
// Valid/ready FIFO with optional half-swap on entry and a registered head output.
// Optional per-entry even parity is enabled by defining BYTE_STREAM_FIFO_PARITY_EN.
module byte_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_swap,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_parity,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef BYTE_STREAM_FIFO_PARITY_EN
    localparam int ENTRY_W = WIDTH + 1;
`else
    localparam int ENTRY_W = WIDTH;
`endif

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ENTRY_W-1:0] r_out_entry;

    logic               w_wr;
    logic               w_rd;
    logic [WIDTH-1:0]   w_wr_word;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [CNT_W-1:0]   w_count_next;
    logic [PTR_W-1:0]   w_wptr_next;
    logic [PTR_W-1:0]   w_rptr_next;
    logic [ENTRY_W-1:0] w_head_next;

    assign w_wr = in_valid && r_in_ready && !flush;
    assign w_rd = r_out_valid && out_ready && !flush;
    assign w_wr_word = in_swap ? {in_data[WIDTH/2-1:0], in_data[WIDTH-1:WIDTH/2]} : in_data;

`ifdef BYTE_STREAM_FIFO_PARITY_EN
    assign w_wr_entry = {^w_wr_word, w_wr_word};
    assign out_parity = r_out_entry[WIDTH];
`else
    assign w_wr_entry = w_wr_word;
    assign out_parity = 1'b0;
`endif

    always_comb begin
        w_count_next = r_count;
        if (w_wr && !w_rd)
            w_count_next = r_count + CNT_W'(1);
        else if (w_rd && !w_wr)
            w_count_next = r_count - CNT_W'(1);
        w_wptr_next = w_wr ? r_wptr + PTR_W'(1) : r_wptr;
        w_rptr_next = w_rd ? r_rptr + PTR_W'(1) : r_rptr;
        // The new head is either the word being written this edge or one already stored.
        w_head_next = r_out_entry;
        if (w_wr && (w_rptr_next == r_wptr))
            w_head_next = w_wr_entry;
        else if (w_count_next != '0)
            w_head_next = r_mem[w_rptr_next];
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= w_wr_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_entry <= '0;
        end else if (flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_next;
            r_rptr      <= w_rptr_next;
            r_count     <= w_count_next;
            r_in_ready  <= (w_count_next < CNT_W'(DEPTH));
            r_out_valid <= (w_count_next != '0);
            r_out_entry <= w_head_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_entry[WIDTH-1:0];
    assign count     = r_count;

endmodule
